// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART transmitter and the matching
//               receiver:
//                 - parity mode constants
//                 - transmit state encoding
//                 - parameter range checks
//                 - parity helper
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity selection values for the PARITY_MODE parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Transmit state. Each state names the bit currently driven on the line.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Legal frame formats, common to transmitter and receiver
  function automatic bit data_bits_ok(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit parity_mode_ok(input int m);
    return (m == PARITY_NONE) || (m == PARITY_ODD) || (m == PARITY_EVEN);
  endfunction

  function automatic bit stop_bits_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

  // Parity bit for a data word zero-extended to 9 bits. The zero padding
  // does not disturb the count of ones.
  // Even: the bit makes the total number of ones even (XOR of the data).
  // Odd : the bit makes the total number of ones odd (inverted XOR).
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmit engine with configurable frame format and a
//               one-entry holding register. A frame waiting in the holding
//               register starts straight after the previous frame's last
//               stop bit, with no idle bit between the two frames.
//
// Parameters  :
//   DATA_BITS   data bits per frame, 5..9, sent LSB first
//   PARITY_MODE 0 none, 1 odd, 2 even
//   STOP_BITS   1 or 2
//
// Ports       :
//   sys_clk    in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tx_clk_en  in   baud tick, one single-cycle pulse per bit period
//   tx_valid   in   upstream has a word on tx_data
//   tx_data    in   word to send, captured on accept
//   tx_ready   out  holding register empty (accept = tx_valid && tx_ready)
//   tx         out  serial line, idle high
//   tx_busy    out  frame on the line or holding register full
//   tx_done    out  one-cycle pulse when the last stop bit completes
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 tx_clk_en,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (!data_bits_ok(DATA_BITS)) begin : g_chk_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (!parity_mode_ok(PARITY_MODE)) begin : g_chk_parity_mode
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : g_chk_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  tx_state_e            state_q;
  logic                 tx_q;
  logic                 done_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;

  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_data_q,  hold_data_d;

  // --------------------------------------------------------------------------
  // Control decodes
  // --------------------------------------------------------------------------
  logic       accept;
  logic       bit_last;
  logic       stop_last;
  logic       load;
  logic [8:0] hold_ext;
  logic       hold_parity;

  // Accept is gated by the registered holding-register flag only, so there
  // is no combinational path from tx_valid to tx_ready.
  assign accept    = tx_valid && !hold_valid_q;
  assign bit_last  = (bit_cnt_q == BIT_LAST);
  assign stop_last = (stop_cnt_q == STOP_LAST);

  // A load takes the held word into the shifter. It happens on a tick when
  // the line is idle, or when the final stop bit completes. Either way the
  // holding register is full, so load and accept can never coincide.
  assign load = tx_clk_en && hold_valid_q &&
                ((state_q == TX_IDLE) || ((state_q == TX_STOP) && stop_last));

  always_comb begin
    hold_ext                = '0;
    hold_ext[DATA_BITS-1:0] = hold_data_q;
  end

  assign hold_parity = parity_bit(hold_ext, PARITY_MODE);

  // --------------------------------------------------------------------------
  // Holding register
  // --------------------------------------------------------------------------
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer
  // The line only changes on baud ticks. The bit for the next state is
  // registered straight into tx_q, so the line never glitches.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (load) begin
            shift_q  <= hold_data_q;
            parity_q <= hold_parity;
            tx_q     <= 1'b0;
            state_q  <= TX_START;
          end else begin
            tx_q <= 1'b1;
          end
        end

        TX_START: begin
          if (tx_clk_en) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= TX_DATA;
          end
        end

        TX_DATA: begin
          if (tx_clk_en) begin
            if (bit_last) begin
              if (HAS_PARITY) begin
                tx_q    <= parity_q;
                state_q <= TX_PARITY;
              end else begin
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= TX_STOP;
              end
            end else begin
              // The shifter moves down one place per bit, so the next data
              // bit always sits at index 1 and bit 0 is the one on the line.
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        TX_PARITY: begin
          if (tx_clk_en) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= TX_STOP;
          end
        end

        TX_STOP: begin
          if (tx_clk_en) begin
            if (stop_last) begin
              done_q <= 1'b1;
              if (load) begin
                // The next frame's start bit follows with no idle gap
                shift_q  <= hold_data_q;
                parity_q <= hold_parity;
                tx_q     <= 1'b0;
                state_q  <= TX_START;
              end else begin
                tx_q    <= 1'b1;
                state_q <= TX_IDLE;
              end
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        // Unused encodings return to a quiet line at once, without waiting
        // for a tick.
        default: begin
          tx_q    <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !hold_valid_q;
  assign tx_busy  = (state_q != TX_IDLE) || hold_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. It builds three
//               instances (8N1, 8E2, 7O1) that share the clock and the baud
//               tick. A queue-based model of the serial bit stream predicts
//               tx, tx_ready, tx_busy and tx_done every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int DB0 = 8, PM0 = 0, SB0 = 1;
  localparam int DB1 = 8, PM1 = 2, SB1 = 2;
  localparam int DB2 = 7, PM2 = 1, SB2 = 1;
  localparam int FIFO_D = 64;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [2:0] valid;
  logic [7:0] din [3];
  logic [2:0] ready;
  logic [2:0] txo;
  logic [2:0] busy;
  logic [2:0] done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per instance, a FIFO of future line bits {last_stop, start, value}
  int         db [3];
  int         pm [3];
  int         sb [3];
  logic [2:0] fifo [3][FIFO_D];
  int         head [3];
  int         tail [3];
  logic       cur_valid [3];
  logic       cur_bit [3];
  logic       cur_last [3];
  int         pending [3];
  logic       exp_done [3];

  uart_tx_frame #(.DATA_BITS(DB0), .PARITY_MODE(PM0), .STOP_BITS(SB0)) u_dut0 (
    .sys_clk(clk), .rst_n(rst_n), .tx_clk_en(tick), .tx_valid(valid[0]),
    .tx_data(din[0][DB0-1:0]), .tx_ready(ready[0]), .tx(txo[0]),
    .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_frame #(.DATA_BITS(DB1), .PARITY_MODE(PM1), .STOP_BITS(SB1)) u_dut1 (
    .sys_clk(clk), .rst_n(rst_n), .tx_clk_en(tick), .tx_valid(valid[1]),
    .tx_data(din[1][DB1-1:0]), .tx_ready(ready[1]), .tx(txo[1]),
    .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_frame #(.DATA_BITS(DB2), .PARITY_MODE(PM2), .STOP_BITS(SB2)) u_dut2 (
    .sys_clk(clk), .rst_n(rst_n), .tx_clk_en(tick), .tx_valid(valid[2]),
    .tx_data(din[2][DB2-1:0]), .tx_ready(ready[2]), .tx(txo[2]),
    .tx_busy(busy[2]), .tx_done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s[%0d] observed=%b expected=%b at %0t", tag, k, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  task automatic model_reset(input int k);
    head[k]      = 0;
    tail[k]      = 0;
    cur_valid[k] = 1'b0;
    cur_bit[k]   = 1'b1;
    cur_last[k]  = 1'b0;
    pending[k]   = 0;
    exp_done[k]  = 1'b0;
  endtask

  task automatic put(input int k, input logic v, input logic st, input logic last);
    fifo[k][tail[k]] = {last, st, v};
    tail[k] = (tail[k] + 1) % FIFO_D;
  endtask

  // A frame is built from the format rules: start 0, data LSB first,
  // optional parity chosen from the count of ones, then the stop bits.
  task automatic push_frame(input int k, input logic [7:0] d);
    int ones;
    ones = 0;
    put(k, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < db[k]; i++) begin
      put(k, d[i], 1'b0, 1'b0);
      ones += int'(d[i]);
    end
    if (pm[k] == 1) put(k, ((ones % 2) == 0), 1'b0, 1'b0);
    if (pm[k] == 2) put(k, ((ones % 2) == 1), 1'b0, 1'b0);
    for (int s = 0; s < sb[k]; s++) put(k, 1'b1, 1'b0, (s == sb[k] - 1));
    pending[k]++;
  endtask

  task automatic model_step(input int k, input logic tk, input logic acc);
    logic [2:0] e;
    if (!rst_n) begin
      model_reset(k);
    end else begin
      exp_done[k] = 1'b0;
      if (tk) begin
        if (cur_valid[k] && cur_last[k]) exp_done[k] = 1'b1;
        if (head[k] != tail[k]) begin
          e = fifo[k][head[k]];
          head[k]      = (head[k] + 1) % FIFO_D;
          cur_valid[k] = 1'b1;
          cur_bit[k]   = e[0];
          cur_last[k]  = e[2];
          if (e[1]) pending[k]--;
        end else begin
          cur_valid[k] = 1'b0;
          cur_bit[k]   = 1'b1;
          cur_last[k]  = 1'b0;
        end
      end
      if (acc) push_frame(k, din[k]);
    end
  endtask

  task automatic check_outputs(input int k);
    chk("tx",       k, txo[k],   cur_valid[k] ? cur_bit[k] : 1'b1);
    chk("tx_ready", k, ready[k], (pending[k] == 0));
    chk("tx_busy",  k, busy[k],  cur_valid[k] || (pending[k] > 0));
    chk("tx_done",  k, done[k],  exp_done[k]);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic cycle(input logic tk);
    logic [2:0] acc;
    tick = tk;
    for (int k = 0; k < 3; k++) acc[k] = valid[k] & ready[k];
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, tk, acc[k]);
    #1;
    tick = 1'b0;
    for (int k = 0; k < 3; k++) if (acc[k]) valid[k] = 1'b0;
    for (int k = 0; k < 3; k++) check_outputs(k);
  endtask

  task automatic run(input int n, input int per);
    for (int i = 0; i < n; i++) cycle((i % per) == (per - 1));
  endtask

  task automatic offer_all(input logic [7:0] d);
    for (int k = 0; k < 3; k++) begin
      din[k]   = d;
      valid[k] = 1'b1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed and random sequence
  // --------------------------------------------------------------------------
  initial begin
    db = '{DB0, DB1, DB2};
    pm = '{PM0, PM1, PM2};
    sb = '{SB0, SB1, SB2};
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      din[k] = 8'h00;
    end
    rst_n = 1'b0;
    tick  = 1'b0;
    valid = 3'b000;

    // Reset, then a long quiet idle period
    run(3, 16);
    #2 rst_n = 1'b1;
    run(100, 16);

    // Single frames: 0x55 / 0xA5 / 0x41
    din[0] = 8'h55; din[1] = 8'hA5; din[2] = 8'h41;
    valid  = 3'b111;
    run(16 * 14, 16);

    // Back-to-back: second word accepted while the first is in its data bits
    offer_all(8'h0F);
    run(16 * 4, 16);
    offer_all(8'hF0);
    run(16 * 28, 16);

    // Reset while data bit 3 is on the line
    offer_all(8'h77);
    run(16 * 5, 16);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      chk("async_rst_tx",    k, txo[k],   1'b1);
      chk("async_rst_ready", k, ready[k], 1'b1);
      chk("async_rst_busy",  k, busy[k],  1'b0);
      chk("async_rst_done",  k, done[k],  1'b0);
    end
    run(2, 16);
    #2 rst_n = 1'b1;
    offer_all(8'h3C);
    run(16 * 14, 16);

    // Random words, tick spacing and offer timing
    for (int it = 0; it < 30; it++) begin
      int per;
      per = int'($urandom_range(1, 8));
      for (int k = 0; k < 3; k++) begin
        if (!valid[k] && ($urandom_range(0, 3) != 0)) begin
          din[k]   = 8'($urandom);
          valid[k] = 1'b1;
        end
      end
      run(per * int'($urandom_range(3, 30)), per);
    end

    // One sys_clk per bit with upstream always offering
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (!valid[k]) begin
          din[k]   = 8'($urandom);
          valid[k] = 1'b1;
        end
      end
      cycle(1'b1);
    end
    valid = 3'b000;
    run(40, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
